// File: rtl/perf_counter_unit.sv
// Performance counter unit: six saturating 32-bit event counters with a RUN/FROZEN
// halt state machine, sticky overflow flags and a fixed one-cycle read port.
module perf_counter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic        halt,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    input  logic        clr,
    input  logic        rd_req,
    input  logic [2:0]  rd_sel,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    output logic [5:0]  ovf,
    output logic        halted
);

    localparam int          NUM_CNT = 6;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t              state;
    logic [31:0]         count [NUM_CNT];
    logic [NUM_CNT-1:0]  inc;
    logic [31:0]         rd_mux;

    // A hit only counts alongside its own request; halt always retires one instruction.
    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = retire | halt;
        inc[2] = icache_req;
        inc[3] = icache_req & icache_hit;
        inc[4] = dcache_req;
        inc[5] = dcache_req & dcache_hit;
    end

    // Indices 6 and 7 have no counter behind them and read as zero.
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            3'd0:    rd_mux = count[0];
            3'd1:    rd_mux = count[1];
            3'd2:    rd_mux = count[2];
            3'd3:    rd_mux = count[3];
            3'd4:    rd_mux = count[4];
            3'd5:    rd_mux = count[5];
            default: rd_mux = '0;
        endcase
    end

    // NOTE: every register here is updated with <= so all reads in this block see
    // pre-edge values; that is what makes the read port return the pre-update count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            ovf     <= '0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                count[i] <= '0;
            end
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
            end

            if (clr) begin
                state <= RUN;
                ovf   <= '0;
                for (int i = 0; i < NUM_CNT; i++) begin
                    count[i] <= '0;
                end
            end else if (state == RUN) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (inc[i]) begin
                        if (count[i] == CNT_MAX) begin
                            ovf[i] <= 1'b1;
                        end else begin
                            count[i] <= count[i] + 32'd1;
                        end
                    end
                end
                if (halt) begin
                    state <= FROZEN;
                end
            end
        end
    end

    assign halted = (state == FROZEN);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed testbench for perf_counter_unit: reset, counting, halt/freeze, saturation,
// clear-with-read and back-to-back reads, each against hand-computed values.
module tb_perf_counter_unit;

    logic        clk = 1'b0;
    logic        rst, retire, halt, icache_req, icache_hit, dcache_req, dcache_hit;
    logic        clr, rd_req;
    logic [2:0]  rd_sel;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [5:0]  ovf;
    logic        halted;

    int checks = 0;
    int errors = 0;

    perf_counter_unit dut (
        .clk        (clk),
        .rst        (rst),
        .retire     (retire),
        .halt       (halt),
        .icache_req (icache_req),
        .icache_hit (icache_hit),
        .dcache_req (dcache_req),
        .dcache_hit (dcache_hit),
        .clr        (clr),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .ovf        (ovf),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        retire = 0; halt = 0; icache_req = 0; icache_hit = 0;
        dcache_req = 0; dcache_hit = 0; clr = 0; rd_req = 0; rd_sel = 3'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        rd_req = 1;
        halt = 1;
        clr = 1;
        step();
        step();
        rst = 0;
        idle_inputs();
        checks++;
        if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", rd_ack); end
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", rd_data); end
        checks++;
        if (ovf !== 6'd0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        // No counting happened on the reset edges, so cycle count before this edge is 0.
        rd_req = 1; rd_sel = 3'd0;
        step();
        rd_req = 0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_cycles: ack %0b data %0d expected ack 1 data 0", rd_ack, rd_data);
        end
    endtask

    task automatic test_retire();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            retire = (i == 1 || i == 3 || i == 4 || i == 8);
            step();
        end
        retire = 0;
        rd_req = 1; rd_sel = 3'd0;
        step();
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd10) begin
            errors++; $display("FAIL retire_cycles: ack %0b data %0d expected ack 1 data 10", rd_ack, rd_data);
        end
        rd_sel = 3'd1;
        step();
        rd_req = 0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd4) begin
            errors++; $display("FAIL retire_instr: ack %0b data %0d expected ack 1 data 4", rd_ack, rd_data);
        end
        step();
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 32'd4) begin
            errors++; $display("FAIL read_idle_hold: ack %0b data %0d expected ack 0 data 4", rd_ack, rd_data);
        end
    endtask

    task automatic test_icache();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            icache_req = 1;
            icache_hit = (i == 0 || i == 2 || i == 5);
            dcache_hit = 1;
            step();
        end
        icache_req = 0; icache_hit = 1;
        step();
        idle_inputs();
        rd_req = 1; rd_sel = 3'd2;
        step();
        checks++;
        if (rd_data !== 32'd6) begin errors++; $display("FAIL icache_req_cnt: got %0d expected 6", rd_data); end
        rd_sel = 3'd3;
        step();
        checks++;
        if (rd_data !== 32'd3) begin errors++; $display("FAIL icache_hit_cnt: got %0d expected 3", rd_data); end
        rd_sel = 3'd5;
        step();
        rd_req = 0;
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL dcache_hit_no_req: got %0d expected 0", rd_data); end
    endtask

    task automatic test_halt();
        apply_reset();
        for (int i = 1; i <= 19; i++) begin
            retire = (i == 5 || i == 10);
            step();
        end
        retire = 1; halt = 1;
        step();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %0b expected 1", halted); end
        for (int i = 0; i < 5; i++) begin
            retire = 1; halt = 1; icache_req = 1; icache_hit = 1; dcache_req = 1; dcache_hit = 1;
            step();
        end
        idle_inputs();
        rd_req = 1; rd_sel = 3'd0;
        step();
        checks++;
        if (rd_data !== 32'd20) begin errors++; $display("FAIL frozen_cycles: got %0d expected 20", rd_data); end
        rd_sel = 3'd1;
        step();
        checks++;
        if (rd_data !== 32'd3) begin errors++; $display("FAIL frozen_instr: got %0d expected 3", rd_data); end
        rd_sel = 3'd2;
        step();
        rd_req = 0;
        checks++;
        if (rd_data !== 32'd0 || halted !== 1'b1) begin
            errors++; $display("FAIL frozen_icache: data %0d halted %0b expected data 0 halted 1", rd_data, halted);
        end
    endtask

    // Continues from the FROZEN state left by test_halt (cycle count 20).
    task automatic test_clr_frozen();
        clr = 1; rd_req = 1; rd_sel = 3'd0;
        step();
        clr = 0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd20) begin
            errors++; $display("FAIL clr_read_preclear: ack %0b data %0d expected ack 1 data 20", rd_ack, rd_data);
        end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL clr_resume: got %0b expected 0", halted); end
        step();
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL clr_cycles_zero: got %0d expected 0", rd_data); end
        step();
        rd_req = 0;
        checks++;
        if (rd_data !== 32'd1) begin errors++; $display("FAIL clr_cycles_one: got %0d expected 1", rd_data); end
    endtask

    task automatic test_saturate();
        apply_reset();
        dut.count[4] = 32'hFFFF_FFFE;
        dcache_req = 1;
        step();
        step();
        step();
        dcache_req = 0;
        checks++;
        if (ovf !== 6'b010000) begin errors++; $display("FAIL sat_ovf: got %b expected 010000", ovf); end
        rd_req = 1; rd_sel = 3'd4;
        step();
        checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_value: got %0h expected ffffffff", rd_data); end
        rd_sel = 3'd7;
        step();
        rd_req = 0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd0) begin
            errors++; $display("FAIL read_sel7: ack %0b data %0h expected ack 1 data 0", rd_ack, rd_data);
        end
        step();
        checks++;
        if (ovf !== 6'b010000) begin errors++; $display("FAIL ovf_sticky: got %b expected 010000", ovf); end
        // Clear must also override a same-cycle halt and increments.
        clr = 1; halt = 1; retire = 1; dcache_req = 1;
        step();
        idle_inputs();
        checks++;
        if (ovf !== 6'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL clr_override: ovf %b halted %0b expected ovf 0 halted 0", ovf, halted);
        end
        rd_req = 1; rd_sel = 3'd4;
        step();
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL clr_cnt4: got %0h expected 0", rd_data); end
        rd_sel = 3'd1;
        step();
        rd_req = 0;
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL clr_instr: got %0d expected 0", rd_data); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        retire = 1; icache_req = 1;
        step();
        step();
        step();
        retire = 0; icache_req = 0;
        rd_req = 1; rd_sel = 3'd1;
        step();
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd3) begin
            errors++; $display("FAIL b2b_first: ack %0b data %0d expected ack 1 data 3", rd_ack, rd_data);
        end
        rd_sel = 3'd6;
        step();
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd0) begin
            errors++; $display("FAIL b2b_sel6: ack %0b data %0d expected ack 1 data 0", rd_ack, rd_data);
        end
        rd_sel = 3'd2;
        step();
        rd_req = 0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 32'd3) begin
            errors++; $display("FAIL b2b_third: ack %0b data %0d expected ack 1 data 3", rd_ack, rd_data);
        end
        step();
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 32'd3) begin
            errors++; $display("FAIL b2b_idle: ack %0b data %0d expected ack 0 data 3", rd_ack, rd_data);
        end
    endtask

    task automatic test_rst_priority();
        apply_reset();
        step();
        step();
        rst = 1; clr = 1; halt = 1; retire = 1; rd_req = 1; rd_sel = 3'd0;
        step();
        rst = 0;
        idle_inputs();
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 32'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL rst_priority: ack %0b data %0d halted %0b expected 0 0 0", rd_ack, rd_data, halted);
        end
        rd_req = 1; rd_sel = 3'd0;
        step();
        rd_req = 0;
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_no_count: got %0d expected 0", rd_data); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_retire();
        test_icache();
        test_halt();
        test_clr_frozen();
        test_saturate();
        test_back_to_back();
        test_rst_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-002 The block SHALL expose these ports:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- retire  in  1  instruction retired this cycle (RegWrite | MemWrite | Halt at the retiring stage).
- halt  in  1  halt instruction retiring this cycle.
- icache_req  in  1  valid instruction-cache request.
- icache_hit  in  1  instruction-cache hit.
- dcache_req  in  1  valid data-cache read/write request.
- dcache_hit  in  1  data-cache hit.
- clr  in  1  clear all counters and resume.
- rd_req  in  1  counter read request.
- rd_sel  in  3  counter index.
- rd_ack  out  1  read data valid.
- rd_data  out  32  selected counter value.
- ovf  out  6  sticky per-counter saturation flags, bit i = counter i.
- halted  out  1  unit frozen after halt.

Function
REQ-003 The block SHALL hold six 32-bit counters: 0 cycles, 1 retired instructions, 2 icache requests, 3 icache hits, 4 dcache requests, 5 dcache hits.
REQ-004 The block SHALL implement a two-state FSM, RUN and FROZEN; halted SHALL be 1 exactly when the state is FROZEN.
REQ-005 In RUN, each counter SHALL increment by 1 per clk edge when its condition holds:
- counter 0: always.
- counter 1: retire | halt (a halt counts once even if retire is also 1).
- counter 2: icache_req.
- counter 3: icache_hit & icache_req.
- counter 4: dcache_req.
- counter 5: dcache_hit & dcache_req.
REQ-006 A hit input without its matching request in the same cycle SHALL be ignored.
REQ-007 In RUN with halt=1, the block SHALL perform that cycle's increments, including cycle and instruction, then enter FROZEN on the same edge.
REQ-008 In FROZEN, no counter SHALL change; further halt, retire and cache inputs SHALL be ignored.
REQ-009 Counters SHALL saturate at 0xFFFF_FFFF and never wrap.
REQ-010 An increment attempted while a counter is at 0xFFFF_FFFF SHALL set ovf[i], which SHALL stay set until clr or rst.
REQ-011 clr=1 SHALL, on that edge:
- zero all counters and ovf;
- put the FSM in RUN;
- override every same-cycle increment and halt, so counters read 0 afterwards.
REQ-012 Reads SHALL have fixed 1-cycle latency. rd_req sampled at edge N SHALL give rd_ack=1 and rd_data = the value of counter rd_sel before edge N's update, both valid from edge N until edge N+1.
REQ-013 rd_req MAY be asserted every cycle; back-to-back reads SHALL each be acknowledged exactly one cycle later, in order.
REQ-014 When rd_req=0 at edge N, rd_ack SHALL be 0 after edge N and rd_data SHALL hold its previous value.
REQ-015 A read of rd_sel 6 or 7 SHALL be acknowledged with rd_data=0.
REQ-016 A read sampled on the same edge as clr SHALL return the pre-clear value.
REQ-017 Reads SHALL work in both RUN and FROZEN.

Reset
REQ-018 On rst=1 at an edge, the block SHALL:
- zero all counters, ovf and rd_data;
- set rd_ack=0;
- enter RUN so that halted=0.
REQ-019 rst SHALL take priority over clr, halt and rd_req; a read pending when rst asserts SHALL be dropped with no ack.
REQ-020 No counter SHALL increment on any edge where rst=1.

Verification
REQ-021 Reset, then 10 cycles with retire=1 on 4 of them, then read sel 0 and sel 1 -> 10 and 4 returned, each one cycle after its request.
REQ-022 Six cycles of icache_req=1, with icache_hit=1 on 3 of them plus icache_hit=1 on one cycle with req=0 -> counter 2 = 6, counter 3 = 3.
REQ-023 halt=1 and retire=1 at cycle 20 after reset, then 5 more cycles -> halted=1, counter 0 = 20, counter 1 counts the halt once, no counter changes afterwards.
REQ-024 Force counter 4 to 0xFFFF_FFFE, then 3 cycles with dcache_req=1 -> counter 4 = 0xFFFF_FFFF, ovf[4]=1, other ovf bits 0.
REQ-025 In FROZEN, clr=1 and rd_req=1 with sel 0 in the same cycle -> rd_data = pre-clear cycle count, halted=0 next cycle, and counter 0 reads 1 one cycle after clr.
REQ-026 Back-to-back rd_req for sels 1, 6, 2 -> three consecutive rd_ack cycles with data of counter 1, then 0, then counter 2.
